// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers for the E stage.
// Latency: mthi/mtlo visible next cycle; mult/multu commit after MULT_LAT busy cycles, div/divu after DIV_LAT.
// Backpressure: stall holds a D-stage HI/LO instruction while an op is starting or in flight; cancel masks E-stage effects.
module md_unit #(
    parameter int MULT_LAT = 5,
    parameter int DIV_LAT  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  op,
    input  logic        hi_sel,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cancel,
    input  logic        d_md,
    output logic        start,
    output logic        busy,
    output logic        stall,
    output logic [31:0] result,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_READ  = 3'd7;

    logic [CW-1:0] cnt;
    logic [31:0]   p_hi, p_lo;
    logic [31:0]   p_hi_nxt, p_lo_nxt;
    logic [CW-1:0] lat_nxt;

    logic          is_arith;
    logic [63:0]   sprod, uprod;
    logic          a_neg, b_neg;
    logic [31:0]   a_mag, b_mag, q_mag, r_mag;
    logic [31:0]   sq, sr;

    assign is_arith = (op >= OP_MULT) && (op <= OP_DIVU);
    assign busy     = (cnt != '0);
    assign start    = is_arith & ~busy & ~cancel;
    assign stall    = d_md & (start | busy);
    assign result   = (op == OP_READ) ? (hi_sel ? hi : lo) : 32'd0;

    assign sprod = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    assign uprod = {32'd0, a} * {32'd0, b};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    assign a_neg = a[31];
    assign b_neg = b[31];
    assign a_mag = a_neg ? (32'd0 - a) : a;
    assign b_mag = b_neg ? (32'd0 - b) : b;
    assign q_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag / b_mag);
    assign r_mag = (b_mag == 32'd0) ? 32'd0 : (a_mag % b_mag);
    assign sq    = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
    assign sr    = a_neg ? (32'd0 - r_mag) : r_mag;

    always_comb begin
        p_hi_nxt = hi;
        p_lo_nxt = lo;
        lat_nxt  = CW'(DIV_LAT);
        case (op)
            OP_MULT: begin
                p_hi_nxt = sprod[63:32];
                p_lo_nxt = sprod[31:0];
                lat_nxt  = CW'(MULT_LAT);
            end
            OP_MULTU: begin
                p_hi_nxt = uprod[63:32];
                p_lo_nxt = uprod[31:0];
                lat_nxt  = CW'(MULT_LAT);
            end
            OP_DIV: begin
                if (b != 32'd0) begin
                    p_hi_nxt = sr;
                    p_lo_nxt = sq;
                end
            end
            OP_DIVU: begin
                if (b != 32'd0) begin
                    p_hi_nxt = a % b;
                    p_lo_nxt = a / b;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt  <= '0;
            p_hi <= 32'd0;
            p_lo <= 32'd0;
            hi   <= 32'd0;
            lo   <= 32'd0;
        end else begin
            if (start) begin
                cnt  <= lat_nxt;
                p_hi <= p_hi_nxt;
                p_lo <= p_lo_nxt;
            end else if (busy) begin
                cnt <= cnt - CW'(1);
            end

            // Commit and mthi/mtlo are exclusive: the moves need ~busy.
            if (cnt == CW'(1)) begin
                hi <= p_hi;
                lo <= p_lo;
            end else if (!busy && !cancel) begin
                if (op == OP_MTHI) hi <= a;
                if (op == OP_MTLO) lo <= a;
            end
        end
    end

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: table of arithmetic vectors plus hand-written multi-cycle sequences.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic [2:0]  op;
    logic        hi_sel;
    logic [31:0] a, b;
    logic        cancel;
    logic        d_md;
    logic        start, busy, stall;
    logic [31:0] result, hi, lo;

    int tests;
    int failed;

    md_unit #(.MULT_LAT(5), .DIV_LAT(10)) dut (
        .clk(clk), .reset(reset), .op(op), .hi_sel(hi_sel), .a(a), .b(b),
        .cancel(cancel), .d_md(d_md), .start(start), .busy(busy),
        .stall(stall), .result(result), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          lat;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic idle();
        op = 3'd0; a = 32'd0; b = 32'd0; cancel = 1'b0; hi_sel = 1'b0;
    endtask

    // Writes HI (op 5) or LO (op 6) in one cycle and returns at the start of the next.
    task automatic move_to(input logic [2:0] mop, input logic [31:0] val);
        op = mop; a = val;
        next_cyc();
        idle();
    endtask

    initial begin
        tests = 0;
        failed = 0;
        reset = 1'b0;
        d_md = 1'b0;
        idle();

        vecs[0] = '{"mult_neg",   3'd1, 32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{"multu",      3'd2, 32'hFFFFFFFE, 32'd3,        32'h00000002, 32'hFFFFFFFA, 5};
        vecs[2] = '{"mult_max",   3'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
        vecs[3] = '{"div_neg",    3'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[4] = '{"divu",       3'd4, 32'd7,        32'd2,        32'h00000001, 32'h00000003, 10};
        vecs[5] = '{"div_ovf",    3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
        vecs[6] = '{"div_negdiv", 3'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
        vecs[7] = '{"divu_big",   3'd4, 32'hFFFFFFFF, 32'd16,       32'h0000000F, 32'h0FFFFFFF, 10};

        #12;
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b1;
        next_cyc();

        // Table-driven arithmetic: start in cycle 0, busy 1..N, committed in N+1.
        foreach (vecs[i]) begin
            op = vecs[i].op; a = vecs[i].a; b = vecs[i].b;
            mid();
            chk({vecs[i].name, "_start"}, {31'd0, start}, 32'd1);
            next_cyc();
            idle();
            for (int k = 1; k <= vecs[i].lat; k++) begin
                mid();
                chk({vecs[i].name, "_busy"}, {31'd0, busy}, 32'd1);
                next_cyc();
            end
            op = 3'd7; hi_sel = 1'b1;
            mid();
            chk({vecs[i].name, "_done"}, {31'd0, busy}, 32'd0);
            chk({vecs[i].name, "_hi"}, hi, vecs[i].exp_hi);
            chk({vecs[i].name, "_lo"}, lo, vecs[i].exp_lo);
            chk({vecs[i].name, "_mfhi"}, result, vecs[i].exp_hi);
            hi_sel = 1'b0;
            #1;
            chk({vecs[i].name, "_mflo"}, result, vecs[i].exp_lo);
            next_cyc();
            idle();
        end

        // Divide by zero keeps preloaded HI/LO and still takes the full latency.
        move_to(3'd5, 32'h11);
        move_to(3'd6, 32'h22);
        op = 3'd7; hi_sel = 1'b1;
        mid();
        chk("mthi_result", result, 32'h11);
        chk("mtlo_lo", lo, 32'h22);
        next_cyc();
        op = 3'd3; a = 32'h1234; b = 32'd0;
        mid();
        chk("dz_start", {31'd0, start}, 32'd1);
        next_cyc();
        idle();
        for (int k = 1; k <= 10; k++) begin
            mid();
            chk("dz_busy", {31'd0, busy}, 32'd1);
            next_cyc();
        end
        mid();
        chk("dz_idle", {31'd0, busy}, 32'd0);
        chk("dz_hi", hi, 32'h11);
        chk("dz_lo", lo, 32'h22);
        next_cyc();

        // Cancelled mult and mtlo leave everything untouched.
        op = 3'd1; a = 32'd9; b = 32'd9; cancel = 1'b1; d_md = 1'b1;
        mid();
        chk("cxl_start", {31'd0, start}, 32'd0);
        chk("cxl_stall", {31'd0, stall}, 32'd0);
        next_cyc();
        op = 3'd6; a = 32'h55; cancel = 1'b1; d_md = 1'b0;
        mid();
        chk("cxl_busy", {31'd0, busy}, 32'd0);
        next_cyc();
        idle();
        mid();
        chk("cxl_hi", hi, 32'h11);
        chk("cxl_lo", lo, 32'h22);
        next_cyc();

        // Stall held through cycles 0..5, released in 6 when mfhi sees the new HI.
        d_md = 1'b1;
        op = 3'd1; a = 32'hFFFFFFFE; b = 32'd3;
        mid();
        chk("stall_c0", {31'd0, stall}, 32'd1);
        next_cyc();
        idle();
        for (int k = 1; k <= 5; k++) begin
            mid();
            chk("stall_busy", {31'd0, stall}, 32'd1);
            next_cyc();
        end
        op = 3'd7; hi_sel = 1'b1;
        mid();
        chk("stall_c6", {31'd0, stall}, 32'd0);
        chk("stall_mfhi", result, 32'hFFFFFFFF);
        next_cyc();
        idle();
        d_md = 1'b0;

        // Cancel during busy cycle 3 (with a move attempt) does not abort the commit.
        op = 3'd1; a = 32'd5; b = 32'd6;
        next_cyc();
        idle();
        next_cyc();
        next_cyc();
        op = 3'd5; a = 32'hDEAD; cancel = 1'b1;
        mid();
        chk("cxlb_busy", {31'd0, busy}, 32'd1);
        next_cyc();
        op = 3'd6; a = 32'hBEEF; cancel = 1'b0;
        next_cyc();
        idle();
        mid();
        chk("cxlb_c5_lo", lo, 32'hFFFFFFFA);
        next_cyc();
        mid();
        chk("cxlb_idle", {31'd0, busy}, 32'd0);
        chk("cxlb_hi", hi, 32'd0);
        chk("cxlb_lo", lo, 32'h1E);
        next_cyc();

        // Reset in cycle 2 of a mult clears state at once; no later commit.
        move_to(3'd5, 32'h77);
        op = 3'd1; a = 32'd3; b = 32'd4;
        next_cyc();
        idle();
        next_cyc();
        #1;
        reset = 1'b0;
        #1;
        chk("rmid_busy", {31'd0, busy}, 32'd0);
        chk("rmid_hi", hi, 32'd0);
        chk("rmid_lo", lo, 32'd0);
        mid();
        reset = 1'b1;
        for (int k = 0; k < 6; k++) next_cyc();
        mid();
        chk("rmid_nocommit_busy", {31'd0, busy}, 32'd0);
        chk("rmid_nocommit_lo", lo, 32'd0);
        chk("rmid_nocommit_hi", hi, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
